// File: rtl/branch_de_em_stage.sv
// rtl/branch_de_em_stage.sv - branch compare plus D/E and E/M pipeline registers
//
// Purpose:
//   Resolves conditional branches combinationally in decode from the forwarded
//   operands. It also holds the decode/execute and execute/memory pipeline
//   registers.
//
// Ports:
//   clk, reset (async, active-low), clr (sync bubble into D/E)
//   RD1, RD2, rt, Opcode, IsBr  -> Br             branch compare
//   *In (D/E data/control)      -> DE_*Out        one-cycle register
//   EResultIn, ERD2In, DE_*     -> EM_*Out        one-cycle register
module branch_de_em_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic [4:0]  rt,
  input  logic [5:0]  Opcode,
  input  logic        IsBr,
  output logic        Br,
  input  logic [31:0] ImmIn,
  input  logic [4:0]  A3In,
  input  logic [4:0]  ShamtIn,
  input  logic [31:0] PCIn,
  input  logic        ALUBSelIn,
  input  logic        MDUENIn,
  input  logic        DMWEIn,
  input  logic        DataWBSelIn,
  input  logic        RegWEIn,
  input  logic [1:0]  EResultSelIn,
  input  logic [7:0]  ALUCtrlIn,
  input  logic [2:0]  SLCtrlIn,
  input  logic [2:0]  MDUCtrlIn,
  output logic [31:0] DE_RD1Out,
  output logic [31:0] DE_RD2Out,
  output logic [31:0] DE_ImmOut,
  output logic [31:0] DE_PCOut,
  output logic [4:0]  DE_A3Out,
  output logic [4:0]  DE_ShamtOut,
  output logic        DE_ALUBSelOut,
  output logic        DE_MDUENOut,
  output logic        DE_DMWEOut,
  output logic        DE_DataWBSelOut,
  output logic        DE_RegWEOut,
  output logic [1:0]  DE_EResultSelOut,
  output logic [7:0]  DE_ALUCtrlOut,
  output logic [2:0]  DE_SLCtrlOut,
  output logic [2:0]  DE_MDUCtrlOut,
  input  logic [31:0] EResultIn,
  input  logic [31:0] ERD2In,
  output logic [31:0] EM_ResultOut,
  output logic [31:0] EM_RD2Out,
  output logic [31:0] EM_PCOut,
  output logic [4:0]  EM_A3Out,
  output logic        EM_DMWEOut,
  output logic        EM_DataWBSelOut,
  output logic        EM_RegWEOut,
  output logic [2:0]  EM_SLCtrlOut
);

  // Signed tests against zero only need the sign bit and a zero detect.
  logic rd1_neg;
  logic rd1_zero;
  logic cond;

  assign rd1_neg  = RD1[31];
  assign rd1_zero = (RD1 == 32'd0);

  always_comb begin
    cond = 1'b0;
    case (Opcode)
      6'b000100: cond = (RD1 == RD2);
      6'b000101: cond = (RD1 != RD2);
      6'b000110: cond = rd1_neg | rd1_zero;
      6'b000111: cond = ~rd1_neg & ~rd1_zero;
      6'b000001: begin
        // REGIMM group: the rt field selects the comparison.
        case (rt)
          5'b00000: cond = rd1_neg;
          5'b00001: cond = ~rd1_neg;
          default:  cond = 1'b0;
        endcase
      end
      default: cond = 1'b0;
    endcase
  end

  assign Br = IsBr & cond;

  // D/E register: clr inserts a bubble (all fields zero) on a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || clr) begin
      DE_RD1Out        <= 32'd0;
      DE_RD2Out        <= 32'd0;
      DE_ImmOut        <= 32'd0;
      DE_PCOut         <= 32'd0;
      DE_A3Out         <= 5'd0;
      DE_ShamtOut      <= 5'd0;
      DE_ALUBSelOut    <= 1'b0;
      DE_MDUENOut      <= 1'b0;
      DE_DMWEOut       <= 1'b0;
      DE_DataWBSelOut  <= 1'b0;
      DE_RegWEOut      <= 1'b0;
      DE_EResultSelOut <= 2'd0;
      DE_ALUCtrlOut    <= 8'd0;
      DE_SLCtrlOut     <= 3'd0;
      DE_MDUCtrlOut    <= 3'd0;
    end else begin
      DE_RD1Out        <= RD1;
      DE_RD2Out        <= RD2;
      DE_ImmOut        <= ImmIn;
      DE_PCOut         <= PCIn;
      DE_A3Out         <= A3In;
      DE_ShamtOut      <= ShamtIn;
      DE_ALUBSelOut    <= ALUBSelIn;
      DE_MDUENOut      <= MDUENIn;
      DE_DMWEOut       <= DMWEIn;
      DE_DataWBSelOut  <= DataWBSelIn;
      DE_RegWEOut      <= RegWEIn;
      DE_EResultSelOut <= EResultSelIn;
      DE_ALUCtrlOut    <= ALUCtrlIn;
      DE_SLCtrlOut     <= SLCtrlIn;
      DE_MDUCtrlOut    <= MDUCtrlIn;
    end
  end

  // E/M register: no clear of its own, so a D/E bubble flows through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      EM_ResultOut    <= 32'd0;
      EM_RD2Out       <= 32'd0;
      EM_PCOut        <= 32'd0;
      EM_A3Out        <= 5'd0;
      EM_DMWEOut      <= 1'b0;
      EM_DataWBSelOut <= 1'b0;
      EM_RegWEOut     <= 1'b0;
      EM_SLCtrlOut    <= 3'd0;
    end else begin
      EM_ResultOut    <= EResultIn;
      EM_RD2Out       <= ERD2In;
      EM_PCOut        <= DE_PCOut;
      EM_A3Out        <= DE_A3Out;
      EM_DMWEOut      <= DE_DMWEOut;
      EM_DataWBSelOut <= DE_DataWBSelOut;
      EM_RegWEOut     <= DE_RegWEOut;
      EM_SLCtrlOut    <= DE_SLCtrlOut;
    end
  end

endmodule

// File: tb/tb_branch_de_em_stage.sv
// tb/tb_branch_de_em_stage.sv - directed self-checking bench for branch_de_em_stage
module tb_branch_de_em_stage;

  logic        clk = 1'b0;
  logic        reset, clr;
  logic [31:0] RD1, RD2;
  logic [4:0]  rt;
  logic [5:0]  Opcode;
  logic        IsBr, Br;
  logic [31:0] ImmIn, PCIn;
  logic [4:0]  A3In, ShamtIn;
  logic        ALUBSelIn, MDUENIn, DMWEIn, DataWBSelIn, RegWEIn;
  logic [1:0]  EResultSelIn;
  logic [7:0]  ALUCtrlIn;
  logic [2:0]  SLCtrlIn, MDUCtrlIn;
  logic [31:0] DE_RD1Out, DE_RD2Out, DE_ImmOut, DE_PCOut;
  logic [4:0]  DE_A3Out, DE_ShamtOut;
  logic        DE_ALUBSelOut, DE_MDUENOut, DE_DMWEOut, DE_DataWBSelOut, DE_RegWEOut;
  logic [1:0]  DE_EResultSelOut;
  logic [7:0]  DE_ALUCtrlOut;
  logic [2:0]  DE_SLCtrlOut, DE_MDUCtrlOut;
  logic [31:0] EResultIn, ERD2In;
  logic [31:0] EM_ResultOut, EM_RD2Out, EM_PCOut;
  logic [4:0]  EM_A3Out;
  logic        EM_DMWEOut, EM_DataWBSelOut, EM_RegWEOut;
  logic [2:0]  EM_SLCtrlOut;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_de_em_stage dut (
    .clk(clk), .reset(reset), .clr(clr),
    .RD1(RD1), .RD2(RD2), .rt(rt), .Opcode(Opcode), .IsBr(IsBr), .Br(Br),
    .ImmIn(ImmIn), .A3In(A3In), .ShamtIn(ShamtIn), .PCIn(PCIn),
    .ALUBSelIn(ALUBSelIn), .MDUENIn(MDUENIn), .DMWEIn(DMWEIn),
    .DataWBSelIn(DataWBSelIn), .RegWEIn(RegWEIn), .EResultSelIn(EResultSelIn),
    .ALUCtrlIn(ALUCtrlIn), .SLCtrlIn(SLCtrlIn), .MDUCtrlIn(MDUCtrlIn),
    .DE_RD1Out(DE_RD1Out), .DE_RD2Out(DE_RD2Out), .DE_ImmOut(DE_ImmOut),
    .DE_PCOut(DE_PCOut), .DE_A3Out(DE_A3Out), .DE_ShamtOut(DE_ShamtOut),
    .DE_ALUBSelOut(DE_ALUBSelOut), .DE_MDUENOut(DE_MDUENOut),
    .DE_DMWEOut(DE_DMWEOut), .DE_DataWBSelOut(DE_DataWBSelOut),
    .DE_RegWEOut(DE_RegWEOut), .DE_EResultSelOut(DE_EResultSelOut),
    .DE_ALUCtrlOut(DE_ALUCtrlOut), .DE_SLCtrlOut(DE_SLCtrlOut),
    .DE_MDUCtrlOut(DE_MDUCtrlOut),
    .EResultIn(EResultIn), .ERD2In(ERD2In),
    .EM_ResultOut(EM_ResultOut), .EM_RD2Out(EM_RD2Out), .EM_PCOut(EM_PCOut),
    .EM_A3Out(EM_A3Out), .EM_DMWEOut(EM_DMWEOut),
    .EM_DataWBSelOut(EM_DataWBSelOut), .EM_RegWEOut(EM_RegWEOut),
    .EM_SLCtrlOut(EM_SLCtrlOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_de_zero(input string tag);
    check({tag, " DE_RD1"},   DE_RD1Out, 32'd0);
    check({tag, " DE_RD2"},   DE_RD2Out, 32'd0);
    check({tag, " DE_Imm"},   DE_ImmOut, 32'd0);
    check({tag, " DE_PC"},    DE_PCOut, 32'd0);
    check({tag, " DE_A3"},    32'(DE_A3Out), 32'd0);
    check({tag, " DE_Shamt"}, 32'(DE_ShamtOut), 32'd0);
    check({tag, " DE_ctl1"},  32'({DE_ALUBSelOut, DE_MDUENOut, DE_DMWEOut,
                                   DE_DataWBSelOut, DE_RegWEOut}), 32'd0);
    check({tag, " DE_ctlN"},  32'({DE_EResultSelOut, DE_ALUCtrlOut,
                                   DE_SLCtrlOut, DE_MDUCtrlOut}), 32'd0);
  endtask

  task automatic check_em_zero(input string tag);
    check({tag, " EM_Result"}, EM_ResultOut, 32'd0);
    check({tag, " EM_RD2"},    EM_RD2Out, 32'd0);
    check({tag, " EM_PC"},     EM_PCOut, 32'd0);
    check({tag, " EM_ctl"},    32'({EM_A3Out, EM_DMWEOut, EM_DataWBSelOut,
                                    EM_RegWEOut, EM_SLCtrlOut}), 32'd0);
  endtask

  task automatic load_nonzero();
    RD1 = 32'h1111_1111; RD2 = 32'h2222_2222; ImmIn = 32'h3333_3333;
    PCIn = 32'h0000_4444; A3In = 5'd7; ShamtIn = 5'd9;
    ALUBSelIn = 1; MDUENIn = 1; DMWEIn = 1; DataWBSelIn = 1; RegWEIn = 1;
    EResultSelIn = 2'd2; ALUCtrlIn = 8'h5A; SLCtrlIn = 3'd5; MDUCtrlIn = 3'd6;
    EResultIn = 32'h5555_5555; ERD2In = 32'h6666_6666;
  endtask

  // Directed branch vectors: isbr, opcode, rt, rd1, rd2, expected Br.
  typedef struct {
    logic        isbr;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
  } br_vec_t;

  br_vec_t br_vecs[] = '{
    '{1, 6'b000100, 5'd0, 32'h1234,     32'h1234,     1'b1},
    '{1, 6'b000100, 5'd0, 32'h1234,     32'h1235,     1'b0},
    '{1, 6'b000101, 5'd0, 32'h1234,     32'h1234,     1'b0},
    '{1, 6'b000101, 5'd0, 32'h1234,     32'h1235,     1'b1},
    '{1, 6'b000001, 5'd0, 32'hFFFFFFFF, 32'h0,        1'b1},
    '{1, 6'b000001, 5'd1, 32'hFFFFFFFF, 32'h0,        1'b0},
    '{1, 6'b000001, 5'd1, 32'h0,        32'h0,        1'b1},
    '{1, 6'b000001, 5'd0, 32'h0,        32'h0,        1'b0},
    '{1, 6'b000001, 5'd2, 32'hFFFFFFFF, 32'h0,        1'b0},
    '{1, 6'b000110, 5'd0, 32'h0,        32'h5,        1'b1},
    '{1, 6'b000111, 5'd0, 32'h0,        32'h5,        1'b0},
    '{1, 6'b000110, 5'd0, 32'h80000000, 32'h0,        1'b1},
    '{1, 6'b000111, 5'd0, 32'h80000000, 32'h0,        1'b0},
    '{1, 6'b000111, 5'd0, 32'h00000001, 32'hFFFFFFFF, 1'b1},
    '{1, 6'b000110, 5'd0, 32'h7FFFFFFF, 32'h0,        1'b0},
    '{1, 6'b001000, 5'd0, 32'h1234,     32'h1234,     1'b0},
    '{0, 6'b000100, 5'd0, 32'h1234,     32'h1234,     1'b0},
    '{0, 6'b000001, 5'd0, 32'hFFFFFFFF, 32'h0,        1'b0}
  };

  initial begin
    reset = 0; clr = 0; rt = 0; Opcode = 0; IsBr = 0;
    load_nonzero();

    // Reset asserted from time zero: registers cleared without a clock edge.
    #2;
    check_de_zero("rst0");
    check_em_zero("rst0");

    // Branch logic is combinational and works even while in reset.
    foreach (br_vecs[i]) begin
      IsBr = br_vecs[i].isbr; Opcode = br_vecs[i].op; rt = br_vecs[i].rt;
      RD1 = br_vecs[i].a; RD2 = br_vecs[i].b;
      #1;
      check($sformatf("br%0d", i), 32'(Br), 32'(br_vecs[i].br));
    end
    IsBr = 0;

    // Release reset mid-cycle; nothing loads until the next rising edge.
    @(negedge clk);
    reset = 1;
    #1;
    check("post_release DE_RegWE", 32'(DE_RegWEOut), 32'd0);

    // Pass-through: one cycle to D/E, two to E/M.
    load_nonzero();
    RegWEIn = 1; A3In = 5'd5; PCIn = 32'h3000;
    @(negedge clk);
    check("de RegWE", 32'(DE_RegWEOut), 32'd1);
    check("de A3",    32'(DE_A3Out), 32'd5);
    check("de PC",    DE_PCOut, 32'h3000);
    check("de RD1",   DE_RD1Out, 32'h1111_1111);
    check("de Imm",   DE_ImmOut, 32'h3333_3333);
    EResultIn = 32'hAB; ERD2In = 32'hCD;
    @(negedge clk);
    check("em A3",     32'(EM_A3Out), 32'd5);
    check("em Result", EM_ResultOut, 32'hAB);
    check("em PC",     EM_PCOut, 32'h3000);
    check("em RD2",    EM_RD2Out, 32'hCD);
    check("em SLCtrl", 32'(EM_SLCtrlOut), 32'd5);
    check("em RegWE",  32'(EM_RegWEOut), 32'd1);

    // Full-width control fields.
    ALUCtrlIn = 8'hFF; MDUCtrlIn = 3'd7; EResultSelIn = 2'd3;
    @(negedge clk);
    check("de ALUCtrl",    32'(DE_ALUCtrlOut), 32'hFF);
    check("de MDUCtrl",    32'(DE_MDUCtrlOut), 32'd7);
    check("de EResultSel", 32'(DE_EResultSelOut), 32'd3);

    // Stall bubble: D/E clears, then E/M sees the bubble one edge later.
    RegWEIn = 1; DMWEIn = 1; clr = 1;
    @(negedge clk);
    check_de_zero("bubble");
    check("pre-bubble em RegWE", 32'(EM_RegWEOut), 32'd1);
    clr = 0;
    @(negedge clk);
    check("bubble em RegWE", 32'(EM_RegWEOut), 32'd0);
    check("bubble em DMWE",  32'(EM_DMWEOut), 32'd0);
    check("bubble em PC",    EM_PCOut, 32'd0);
    check("reload de RegWE", 32'(DE_RegWEOut), 32'd1);

    // Asynchronous reset between edges with nonzero state; clr high too.
    @(negedge clk);
    check("pre-rst em DMWE", 32'(EM_DMWEOut), 32'd1);
    #2;
    reset = 0; clr = 1;
    #1;
    check_de_zero("async");
    check_em_zero("async");
    @(negedge clk);
    check("rst held de RegWE", 32'(DE_RegWEOut), 32'd0);
    reset = 1; clr = 0;
    @(negedge clk);
    check("after rst de A3", 32'(DE_A3Out), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_de_em_stage.md
BRANCH_DE_EM_STAGE -- requirements
Module: branch_de_em_stage

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all registers update on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears every register while low.
REQ-004 clr  input  1  stall bubble: synchronous clear of the D/E register (driven by stall).
REQ-005 RD1, RD2  input  32 each  forwarded decode-stage operands (compare sources and D/E data).
REQ-006 rt  input  5  instruction bits [20:16]; Opcode  input  6  instruction bits [31:26].
REQ-007 IsBr  input  1  decoded instruction is a conditional branch.
REQ-008 Br  output  1  branch-taken flag (combinational).
REQ-009 ImmIn  input  32; A3In  input  5; ShamtIn  input  5; PCIn  input  32  D/E data.
REQ-010 ALUBSelIn, MDUENIn, DMWEIn, DataWBSelIn, RegWEIn  input  1 each; EResultSelIn  input  2; ALUCtrlIn  input  8; SLCtrlIn, MDUCtrlIn  input  3 each  D/E control.
REQ-011 DE_RD1Out, DE_RD2Out, DE_ImmOut, DE_PCOut  output  32 each; DE_A3Out, DE_ShamtOut  output  5 each.
REQ-012 DE_ALUBSelOut, DE_MDUENOut, DE_DMWEOut, DE_DataWBSelOut, DE_RegWEOut  output  1 each; DE_EResultSelOut  output  2; DE_ALUCtrlOut  output  8; DE_SLCtrlOut, DE_MDUCtrlOut  output  3 each.
REQ-013 EResultIn, ERD2In  input  32 each  execute-stage result and forwarded rt value for E/M.
REQ-014 EM_ResultOut, EM_RD2Out, EM_PCOut  output  32 each; EM_A3Out  output  5; EM_DMWEOut, EM_DataWBSelOut, EM_RegWEOut  output  1 each; EM_SLCtrlOut  output  3.

Function
REQ-015 Br = IsBr AND cond; IsBr=0 forces Br=0 regardless of operands.
REQ-016 cond by Opcode: 000100 RD1==RD2; 000101 RD1!=RD2; 000110 signed RD1<=0; 000111 signed RD1>0.
REQ-017 Opcode 000001: rt=00000 signed RD1<0; rt=00001 signed RD1>=0; other rt values cond=0.
REQ-018 Any other Opcode: cond=0; RD2 ignored for 000110/000111/000001.
REQ-019 Signed compares use two's complement bit 31 (0x80000000 is negative).
REQ-020 D/E register: each rising edge with clr=0 loads every D/E input into its DE_* output; no enable.
REQ-021 clr=1 at edge: all D/E fields load 0 (bubble: RegWE=0, DMWE=0, MDUEN=0, PC=0).
REQ-022 E/M register: each rising edge loads ResultOut<=EResultIn, RD2Out<=ERD2In; A3, DMWE, DataWBSel, RegWE, SLCtrl, PC from current DE_* outputs.
REQ-023 E/M has no clear/enable; a D/E bubble propagates to E/M on the following edge.
REQ-024 Latency: D input to DE_* one cycle; D input to EM_* (pass-through fields) two cycles.
REQ-025 clr and reset simultaneous: reset dominates (asynchronous).
REQ-026 Br combinational, same cycle as inputs; no registered state in branch logic.

Reset
REQ-027 While reset=0 all DE_* and EM_* outputs are 0 immediately (no clock needed); Br remains combinational.
REQ-028 Reset release mid-cycle: first load on next rising edge.

Verification
REQ-029 IsBr=1, Opcode=000100, RD1=RD2=0x1234 -> Br=1; RD2=0x1235 -> Br=0; Opcode=000101 inverts.
REQ-030 Opcode=000001, RD1=0xFFFFFFFF: rt=0 -> Br=1, rt=1 -> Br=0; RD1=0, Opcode=000110 -> 1, 000111 -> 0; IsBr=0 -> Br=0.
REQ-031 RegWEIn=1, A3In=5, PCIn=0x3000, clr=0; edge -> DE_RegWEOut=1, DE_A3Out=5; next edge with EResultIn=0xAB -> EM_A3Out=5, EM_ResultOut=0xAB, EM_PCOut=0x3000.
REQ-032 clr=1 with RegWEIn=1, DMWEIn=1 -> after edge all DE_* =0; following edge EM_RegWEOut=0, EM_DMWEOut=0.
REQ-033 Load nonzero values, drive reset=0 between edges -> all DE_*/EM_* read 0 before next edge.
REQ-034 ALUCtrlIn=0xFF, MDUCtrlIn=7, EResultSelIn=3 -> reproduced exactly on DE_* after one edge (full-width check).
